mem_req_responder: RTL and testbench

Memory-side responder for the 4-byte val/rdy memory protocol that the pipelined processor issues on its imem and dmem ports. It accepts `mem_req_4B_t` requests and executes them against an internal word-addressed array. After a programmable fixed latency it returns `mem_resp_4B_t` responses. It serves as a synthesizable single-port memory and test target behind the processor's bypass queues, one instance per port.

---
 rtl/mem_req_responder_pkg.sv | 64 ++++++
 rtl/mem_req_responder_array.sv | 36 +++
 rtl/mem_req_responder.sv | 138 +++++++++++++
 tb/tb_mem_req_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_responder_pkg.sv
// mem_req_responder_pkg
//   Shared message layouts and constants for the 4-byte val/rdy memory
//   protocol. It also holds two small helpers for byte-lane math that the
//   responder uses.
//   Contents:
//     mem_req_4B_t   {type_ 3, opaque 8, addr 32, len 2, data 32}  (77 bits)
//     mem_resp_4B_t  {type_ 3, opaque 8, test 2, len 2, data 32}  (47 bits)
//     MEM_REQ_TYPE_*   request type_ codes
//     MEM_RESP_TEST_*  response test-field codes
package mem_req_responder_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] MEM_REQ_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_REQ_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_REQ_TYPE_INIT  = 3'd2;

  localparam logic [1:0] MEM_RESP_TEST_OK      = 2'b00;
  localparam logic [1:0] MEM_RESP_TEST_OOR     = 2'b01;
  localparam logic [1:0] MEM_RESP_TEST_BADTYPE = 2'b10;

  // Byte enables for an access of the given length starting at the given
  // lane. Lanes shifted past lane 3 fall off the top, so an access never
  // spills into the next word.
  function automatic logic [3:0] mem_lane_mask(input logic [1:0] len,
                                               input logic [1:0] offset);
    logic [7:0] lanes;
    case (len)
      2'd1:    lanes = 8'h01;
      2'd2:    lanes = 8'h03;
      2'd3:    lanes = 8'h07;
      default: lanes = 8'h0F;
    endcase
    lanes = lanes << offset;
    return lanes[3:0];
  endfunction

  // Bit mask that keeps the low nbytes of a right-aligned read.
  function automatic logic [31:0] mem_len_datamask(input logic [1:0] len);
    logic [31:0] mask;
    case (len)
      2'd1:    mask = 32'h0000_00FF;
      2'd2:    mask = 32'h0000_FFFF;
      2'd3:    mask = 32'h00FF_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_req_responder_array.sv
// mem_req_responder_array
//   Word-organised storage behind mem_req_responder. It has a single shared
//   index, a synchronous write with per-byte enables, and a combinational read.
//   Contents are not reset.
//   Ports:
//     clk      in   clock
//     idx      in   word index for both read and write
//     wr_be    in   per-byte write enables (bit b writes byte lane b)
//     wr_data  in   write data, already lane aligned
//     rd_data  out  current contents of word idx
module mem_req_responder_array
  import mem_req_responder_pkg::*;
#(
  parameter int unsigned p_mem_nwords = 256,
  parameter int unsigned p_idx_bits   = 8
) (
  input  logic                  clk,
  input  logic [p_idx_bits-1:0] idx,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [p_mem_nwords];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/mem_req_responder.sv
// mem_req_responder
//   Memory-side responder for the 4-byte val/rdy memory protocol. It accepts
//   one request at a time and performs the access at the accept edge. It
//   returns the latched response p_latency cycles later and holds it until
//   the consumer takes it.
//   Ports:
//     clk       in   clock
//     reset     in   asynchronous reset, active LOW despite its name
//     req_msg   in   mem_req_4B_t (77 bits)
//     req_val   in   request valid
//     req_rdy   out  ready to accept a request (registered)
//     resp_msg  out  mem_resp_4B_t (47 bits, registered)
//     resp_val  out  response valid (registered)
//     resp_rdy  in   consumer accepts the response
module mem_req_responder
  import mem_req_responder_pkg::*;
#(
  parameter int unsigned p_mem_nwords = 256,
  parameter int unsigned p_latency    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [76:0] req_msg,
  input  logic        req_val,
  output logic        req_rdy,
  output logic [46:0] resp_msg,
  output logic        resp_val,
  input  logic        resp_rdy
);

  localparam int unsigned c_idx_bits = $clog2(p_mem_nwords);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] c_count_load   = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;
  localparam logic [1:0] c_after_accept = (p_latency > 0) ? WAIT : RESP;

  logic [1:0]   state;
  logic [3:0]   count;
  logic         out_of_reset;
  mem_resp_4B_t resp_q;
  mem_resp_4B_t resp_next;

  mem_req_4B_t  req;
  logic [29:0]  word_idx;
  logic [1:0]   offset;
  logic         in_range;
  logic         is_read;
  logic         is_write;
  logic         accept;
  logic [3:0]   wr_be;
  logic [31:0]  wr_data;
  logic [31:0]  rd_word;
  logic [31:0]  rd_data;

  assign req      = mem_req_4B_t'(req_msg);
  assign word_idx = req.addr[31:2];
  assign offset   = req.addr[1:0];
  assign in_range = {2'b00, word_idx} < p_mem_nwords;
  assign is_read  = (req.type_ == MEM_REQ_TYPE_READ);
  assign is_write = (req.type_ == MEM_REQ_TYPE_WRITE) || (req.type_ == MEM_REQ_TYPE_INIT);

  // The extra out_of_reset flop keeps req_rdy low during reset and the cycle
  // it is released in, even though the FSM already sits in IDLE.
  assign req_rdy  = (state == IDLE) && out_of_reset;
  assign resp_val = (state == RESP);
  assign resp_msg = resp_q;
  assign accept   = req_rdy && req_val;

  // Out-of-range writes must not alias onto a low word through the truncated
  // index, so the enables are gated by the range check.
  assign wr_be   = (accept && is_write && in_range) ? mem_lane_mask(req.len, offset) : 4'b0000;
  assign wr_data = req.data << {offset, 3'b000};
  assign rd_data = (rd_word >> {offset, 3'b000}) & mem_len_datamask(req.len);

  mem_req_responder_array #(
    .p_mem_nwords(p_mem_nwords),
    .p_idx_bits  (c_idx_bits)
  ) u_array (
    .clk    (clk),
    .idx    (word_idx[c_idx_bits-1:0]),
    .wr_be  (wr_be),
    .wr_data(wr_data),
    .rd_data(rd_word)
  );

  always_comb begin
    resp_next        = '0;
    resp_next.type_  = req.type_;
    resp_next.opaque = req.opaque;
    resp_next.len    = req.len;
    if (!(is_read || is_write)) begin
      resp_next.test = MEM_RESP_TEST_BADTYPE;
    end else if (!in_range) begin
      resp_next.test = MEM_RESP_TEST_OOR;
    end else if (is_read) begin
      resp_next.data = rd_data;
    end
  end

  // In WAIT the counter is checked before it is decremented. A load of
  // p_latency-1 therefore spends exactly p_latency edges between accept and RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      out_of_reset <= 1'b0;
      resp_q       <= '0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            resp_q <= resp_next;
            count  <= c_count_load;
            state  <= c_after_accept;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_responder.sv
// tb_mem_req_responder
//   Drives two responders in parallel: dut0 with latency 0 and dut3 with
//   latency 3, both 256 words deep. A byte-addressed reference memory and a
//   transaction-level timing model predict the outputs of both, and every
//   cycle is compared against them. The directed sequences also pin
//   hand-computed literal responses.
module tb_mem_req_responder;

  logic        clk;
  logic        reset;
  logic [76:0] req_msg_s  [2];
  logic        req_val_s  [2];
  logic        req_rdy_s  [2];
  logic [46:0] resp_msg_s [2];
  logic        resp_val_s [2];
  logic        resp_rdy_s [2];

  int tests = 0;
  int fails = 0;

  mem_req_responder #(.p_mem_nwords(256), .p_latency(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_msg(req_msg_s[0]), .req_val(req_val_s[0]), .req_rdy(req_rdy_s[0]),
    .resp_msg(resp_msg_s[0]), .resp_val(resp_val_s[0]), .resp_rdy(resp_rdy_s[0])
  );

  mem_req_responder #(.p_mem_nwords(256), .p_latency(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_msg(req_msg_s[1]), .req_val(req_val_s[1]), .req_rdy(req_rdy_s[1]),
    .resp_msg(resp_msg_s[1]), .resp_val(resp_val_s[1]), .resp_rdy(resp_rdy_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                         input logic [31:0] addr, input logic [1:0] len,
                                         input logic [31:0] data);
    return {t, op, addr, len, data};
  endfunction

  function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                          input logic [1:0] test, input logic [1:0] len,
                                          input logic [31:0] data);
    return {t, op, test, len, data};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: byte-addressed memory (1024 bytes per instance) plus
  // transaction timing (busy flag and the edge after which the response shows).
  logic [7:0]  mem_b [2][1024];
  logic [46:0] exp_resp [2];
  bit          busy [2];
  int          valid_edge [2];
  int          edge_n = 0;
  bit          up = 1'b0;

  task automatic model_access(input int d, input logic [76:0] m, output logic [46:0] r);
    logic [2:0]  t;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [1:0]  test;
    int nb, off, widx;
    {t, op, addr, len, data} = m;
    nb    = (len == 2'd0) ? 4 : int'(len);
    off   = int'(addr % 4);
    rdata = '0;
    test  = 2'b00;
    if (t > 3'd2) begin
      test = 2'b10;
    end else if (addr / 4 >= 32'd256) begin
      test = 2'b01;
    end else begin
      widx = int'(addr / 4);
      for (int k = 0; k < nb; k++) begin
        if (off + k < 4) begin
          if (t == 3'd0) rdata[8*k +: 8] = mem_b[d][widx*4 + off + k];
          else           mem_b[d][widx*4 + off + k] = data[8*k +: 8];
        end
      end
    end
    r = {t, op, test, len, rdata};
  endtask

  always @(negedge reset) begin
    up = 1'b0;
    for (int d = 0; d < 2; d++) busy[d] = 1'b0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      up = 1'b0;
      for (int d = 0; d < 2; d++) busy[d] = 1'b0;
    end else begin
      edge_n++;
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) begin
          if (edge_n > valid_edge[d] && resp_rdy_s[d]) busy[d] = 1'b0;
        end else if (up && req_val_s[d]) begin
          model_access(d, req_msg_s[d], exp_resp[d]);
          busy[d]       = 1'b1;
          valid_edge[d] = edge_n + lat_of(d);
        end
      end
      up = 1'b1;
    end
  end

  logic exp_rdy, exp_val;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_rdy = reset && up && !busy[d];
      exp_val = reset && busy[d] && (edge_n >= valid_edge[d]);
      checkOutput($sformatf("d%0d req_rdy", d), 64'(req_rdy_s[d]), 64'(exp_rdy));
      checkOutput($sformatf("d%0d resp_val", d), 64'(resp_val_s[d]), 64'(exp_val));
      if (!reset)
        checkOutput($sformatf("d%0d resp_msg reset", d), 64'(resp_msg_s[d]), 64'd0);
      else if (exp_val)
        checkOutput($sformatf("d%0d resp_msg", d), 64'(resp_msg_s[d]), 64'(exp_resp[d]));
    end
  end

  // Presents one request and waits for it to be accepted. It then waits for
  // the response and returns, at a falling edge, the message and the number
  // of cycles between the accept edge and resp_val. If resp_rdy is high it
  // also lets the handshake edge pass before returning.
  task automatic applyStimulus(input int d, input logic [2:0] t, input logic [7:0] op,
                               input logic [31:0] addr, input logic [1:0] len,
                               input logic [31:0] data,
                               output logic [46:0] resp, output int lat);
    int cyc;
    req_msg_s[d] = mk_req(t, op, addr, len, data);
    req_val_s[d] = 1'b1;
    cyc = 0;
    while (!req_rdy_s[d] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      tests++;
      fails++;
      $display("[TB] FAIL d%0d accept timeout: req_rdy never rose", d);
    end
    @(posedge clk);
    @(negedge clk);
    req_val_s[d] = 1'b0;
    req_msg_s[d] = '0;
    lat = 0;
    while (!resp_val_s[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      tests++;
      fails++;
      $display("[TB] FAIL d%0d response timeout: resp_val never rose", d);
    end
    resp = resp_msg_s[d];
    if (resp_rdy_s[d]) @(negedge clk);
  endtask

  logic [46:0] r;
  int          l;

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_msg_s[d]  = '0;
      req_val_s[d]  = 1'b0;
      resp_rdy_s[d] = 1'b1;
    end
    @(negedge clk);
    checkOutput("reset req_rdy", 64'(req_rdy_s[0]), 64'd0);
    checkOutput("reset resp_val", 64'(resp_val_s[0]), 64'd0);
    checkOutput("reset resp_msg", 64'(resp_msg_s[1]), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("req_rdy after reset", 64'(req_rdy_s[0]), 64'd1);

    // Latency 0: full-word write and read back
    applyStimulus(0, 3'd1, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF, r, l);
    checkOutput("wr 0x10 resp", 64'(r), 64'(mk_resp(3'd1, 8'h01, 2'b00, 2'd0, 32'h0)));
    checkOutput("wr 0x10 latency", 64'(l), 64'd0);
    applyStimulus(0, 3'd0, 8'h02, 32'h10, 2'd0, 32'h0, r, l);
    checkOutput("rd 0x10 resp", 64'(r), 64'(mk_resp(3'd0, 8'h02, 2'b00, 2'd0, 32'hDEADBEEF)));

    // Subword write into lane 3, then unaligned halfword reads
    applyStimulus(0, 3'd2, 8'h03, 32'h10, 2'd0, 32'h11223344, r, l);
    applyStimulus(0, 3'd1, 8'h04, 32'h13, 2'd1, 32'h000000AB, r, l);
    applyStimulus(0, 3'd0, 8'h05, 32'h10, 2'd0, 32'h0, r, l);
    checkOutput("rd word after subword wr", 64'(r), 64'(mk_resp(3'd0, 8'h05, 2'b00, 2'd0, 32'hAB223344)));
    applyStimulus(0, 3'd0, 8'h06, 32'h12, 2'd2, 32'h0, r, l);
    checkOutput("rd half @0x12", 64'(r), 64'(mk_resp(3'd0, 8'h06, 2'b00, 2'd2, 32'h0000AB22)));
    applyStimulus(0, 3'd0, 8'h07, 32'h11, 2'd2, 32'h0, r, l);
    checkOutput("rd half @0x11", 64'(r), 64'(mk_resp(3'd0, 8'h07, 2'b00, 2'd2, 32'h00002233)));

    // Backpressure: response must hold while resp_rdy is low
    resp_rdy_s[0] = 1'b0;
    applyStimulus(0, 3'd0, 8'h42, 32'h10, 2'd0, 32'h0, r, l);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp resp_msg", 64'(resp_msg_s[0]), 64'(mk_resp(3'd0, 8'h42, 2'b00, 2'd0, 32'hAB223344)));
      checkOutput("bp req_rdy", 64'(req_rdy_s[0]), 64'd0);
    end
    resp_rdy_s[0] = 1'b1;
    @(negedge clk);
    checkOutput("bp released resp_val", 64'(resp_val_s[0]), 64'd0);
    checkOutput("bp released req_rdy", 64'(req_rdy_s[0]), 64'd1);

    // Out of range, lane drop at the word edge, last valid word, bad type
    applyStimulus(0, 3'd1, 8'h10, 32'h0, 2'd0, 32'h01020304, r, l);
    applyStimulus(0, 3'd1, 8'h11, 32'h400, 2'd0, 32'hFFFFFFFF, r, l);
    checkOutput("oor wr resp", 64'(r), 64'(mk_resp(3'd1, 8'h11, 2'b01, 2'd0, 32'h0)));
    applyStimulus(0, 3'd0, 8'h12, 32'h0, 2'd0, 32'h0, r, l);
    checkOutput("rd 0x0 after oor wr", 64'(r), 64'(mk_resp(3'd0, 8'h12, 2'b00, 2'd0, 32'h01020304)));
    applyStimulus(0, 3'd0, 8'h13, 32'h400, 2'd0, 32'h0, r, l);
    checkOutput("oor rd resp", 64'(r), 64'(mk_resp(3'd0, 8'h13, 2'b01, 2'd0, 32'h0)));
    applyStimulus(0, 3'd1, 8'h14, 32'h3, 2'd3, 32'h00C0FFEE, r, l);
    applyStimulus(0, 3'd0, 8'h15, 32'h0, 2'd0, 32'h0, r, l);
    checkOutput("lane drop word", 64'(r), 64'(mk_resp(3'd0, 8'h15, 2'b00, 2'd0, 32'hEE020304)));
    applyStimulus(0, 3'd0, 8'h16, 32'h3, 2'd0, 32'h0, r, l);
    checkOutput("rd @0x3 len4", 64'(r), 64'(mk_resp(3'd0, 8'h16, 2'b00, 2'd0, 32'h000000EE)));
    applyStimulus(0, 3'd1, 8'h17, 32'h3FC, 2'd0, 32'h55AA55AA, r, l);
    checkOutput("wr last word", 64'(r), 64'(mk_resp(3'd1, 8'h17, 2'b00, 2'd0, 32'h0)));
    applyStimulus(0, 3'd0, 8'h18, 32'h3FC, 2'd0, 32'h0, r, l);
    checkOutput("rd last word", 64'(r), 64'(mk_resp(3'd0, 8'h18, 2'b00, 2'd0, 32'h55AA55AA)));
    applyStimulus(0, 3'd5, 8'h19, 32'h10, 2'd1, 32'h12345678, r, l);
    checkOutput("bad type resp", 64'(r), 64'(mk_resp(3'd5, 8'h19, 2'b10, 2'd1, 32'h0)));

    // Latency 3
    applyStimulus(1, 3'd1, 8'h20, 32'h20, 2'd0, 32'h0BADF00D, r, l);
    checkOutput("lat3 wr latency", 64'(l), 64'd3);
    applyStimulus(1, 3'd0, 8'h5A, 32'h20, 2'd0, 32'h0, r, l);
    checkOutput("lat3 rd latency", 64'(l), 64'd3);
    checkOutput("lat3 rd resp", 64'(r), 64'(mk_resp(3'd0, 8'h5A, 2'b00, 2'd0, 32'h0BADF00D)));

    // Reset while dut3 waits on an accepted write
    req_msg_s[1] = mk_req(3'd1, 8'h77, 32'h24, 2'd0, 32'hCAFEF00D);
    req_val_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val_s[1] = 1'b0;
    req_msg_s[1] = '0;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst in WAIT resp_val", 64'(resp_val_s[1]), 64'd0);
    checkOutput("rst in WAIT req_rdy", 64'(req_rdy_s[1]), 64'd0);
    checkOutput("rst in WAIT resp_msg", 64'(resp_msg_s[1]), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("rdy after mid reset", 64'(req_rdy_s[1]), 64'd1);
    applyStimulus(1, 3'd0, 8'h78, 32'h24, 2'd0, 32'h0, r, l);
    checkOutput("write survives reset", 64'(r), 64'(mk_resp(3'd0, 8'h78, 2'b00, 2'd0, 32'hCAFEF00D)));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
